add_rs_dispatch: RTL

- Three-entry reservation station for the add/sub functional unit; sits directly upstream of the add/sub execution unit.
- Accepts issued instructions and captures operand values by register-tag broadcast from the common data bus (CDB).
- Selects the oldest ready entry and launches it to the execution unit.
- Frees the entry when the execution unit reports completion.

---
 rtl/tomasulo_pkg.sv | 34 +++
 rtl/rs_oldest_select.sv | 29 ++
 rtl/add_rs_dispatch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo add/sub reservation station.
package tomasulo_pkg;

    localparam int DW      = 8;   // operand data width
    localparam int TW      = 4;   // register tag width
    localparam int RW      = 3;   // ROB index width
    localparam int IW      = 3;   // reservation-station index width
    localparam int NUM_ENT = 3;   // reservation-station entries

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } rs_state_t;

    typedef struct packed {
        logic [3:0]    func;
        logic [TW-1:0] rd;
        logic [RW-1:0] rob;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [TW-1:0] q1;
        logic [TW-1:0] q2;
        logic          r1;
        logic          r2;
        logic [1:0]    age;
        rs_state_t     state;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational picker: returns the READY entry with the greatest age,
// lowest index winning on ties.
module rs_oldest_select
    import tomasulo_pkg::*;
(
    input  logic [NUM_ENT-1:0]   ready,
    input  logic [2*NUM_ENT-1:0] ages,
    output logic                 sel_valid,
    output logic [IW-1:0]        sel_index
);

    logic [1:0] best_age;

    // Scan upward; a strictly greater age is needed to displace the current
    // pick, so equal ages keep the lower index.
    always_comb begin
        sel_valid = 1'b0;
        sel_index = '0;
        best_age  = 2'd0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (ready[i] && (!sel_valid || ages[2*i +: 2] > best_age)) begin
                sel_valid = 1'b1;
                sel_index = IW'(i);
                best_age  = ages[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/add_rs_dispatch.sv
// Three-entry reservation station feeding the add/sub execution unit:
// allocation, CDB wakeup, oldest-ready dispatch and completion release.
module add_rs_dispatch
    import tomasulo_pkg::*;
(
    input  logic          clk1,
    input  logic          rst,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [3:0]    iss_func,
    input  logic [TW-1:0] iss_rd,
    input  logic [RW-1:0] iss_rob,
    input  logic [DW-1:0] iss_v1,
    input  logic [DW-1:0] iss_v2,
    input  logic [TW-1:0] iss_q1,
    input  logic [TW-1:0] iss_q2,
    input  logic          iss_r1,
    input  logic          iss_r2,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_tag,
    input  logic [DW-1:0] cdb_data,
    input  logic          ex_busy,
    output logic          disp_valid,
    output logic [3:0]    disp_func,
    output logic [DW-1:0] disp_rs1_data,
    output logic [DW-1:0] disp_rs2_data,
    output logic [RW-1:0] disp_rob,
    output logic [TW-1:0] disp_rd,
    output logic [IW-1:0] disp_rs_index,
    input  logic          ex_done,
    input  logic [IW-1:0] ex_done_index,
    output logic [1:0]    occ_count,
    output logic          err_ovf
);

    rs_entry_t ent_reg  [NUM_ENT];
    rs_entry_t ent_next [NUM_ENT];
    rs_entry_t alloc_entry;
    rs_entry_t sel_entry;

    logic [NUM_ENT-1:0]   free_vec;
    logic [NUM_ENT-1:0]   ready_vec;
    logic [NUM_ENT-1:0]   exec_vec;
    logic [2*NUM_ENT-1:0] age_vec;

    logic          iss_ready_reg;
    logic          iss_ready_next;
    logic          iss_accept;
    logic          alloc_found;
    logic [IW-1:0] alloc_idx;
    logic          sel_valid;
    logic [IW-1:0] sel_index;
    logic          disp_fire;
    logic          new_r1;
    logic          new_r2;

    logic          disp_valid_reg;
    logic [3:0]    disp_func_reg;
    logic [DW-1:0] disp_rs1_reg;
    logic [DW-1:0] disp_rs2_reg;
    logic [RW-1:0] disp_rob_reg;
    logic [TW-1:0] disp_rd_reg;
    logic [IW-1:0] disp_idx_reg;
    logic          err_ovf_reg;

    // Per-entry status flags flattened for the picker and control logic.
    generate
        for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_flags
            assign free_vec[gi]          = (ent_reg[gi].state == FREE);
            assign ready_vec[gi]         = (ent_reg[gi].state == READY);
            assign exec_vec[gi]          = (ent_reg[gi].state == EXEC);
            assign age_vec[2*gi +: 2]    = ent_reg[gi].age;
        end
    endgenerate

    rs_oldest_select u_select (
        .ready     (ready_vec),
        .ages      (age_vec),
        .sel_valid (sel_valid),
        .sel_index (sel_index)
    );

    assign iss_accept = iss_valid && iss_ready_reg && alloc_found;
    assign disp_fire  = !ex_busy && !(|exec_vec) && sel_valid;

    // Lowest-index free slot for the next allocation.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IW'(i);
            end
        end
    end

    // New entry image, bypassing a same-cycle CDB broadcast into missing operands.
    always_comb begin
        new_r1 = iss_r1 || (cdb_valid && iss_q1 == cdb_tag);
        new_r2 = iss_r2 || (cdb_valid && iss_q2 == cdb_tag);
        alloc_entry       = '0;
        alloc_entry.func  = iss_func;
        alloc_entry.rd    = iss_rd;
        alloc_entry.rob   = iss_rob;
        alloc_entry.q1    = iss_q1;
        alloc_entry.q2    = iss_q2;
        alloc_entry.v1    = iss_r1 ? iss_v1 : cdb_data;
        alloc_entry.v2    = iss_r2 ? iss_v2 : cdb_data;
        alloc_entry.r1    = new_r1;
        alloc_entry.r2    = new_r2;
        alloc_entry.age   = 2'd0;
        alloc_entry.state = (new_r1 && new_r2) ? READY : WAIT;
    end

    // Entry-level next state: ageing, wakeup, dispatch, completion, allocation.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            ent_next[i] = ent_reg[i];
            if (iss_accept && ent_reg[i].state != FREE && ent_reg[i].age != 2'b11)
                ent_next[i].age = ent_reg[i].age + 2'd1;
            case (ent_reg[i].state)
                WAIT: begin
                    if (cdb_valid && !ent_reg[i].r1 && ent_reg[i].q1 == cdb_tag) begin
                        ent_next[i].v1 = cdb_data;
                        ent_next[i].r1 = 1'b1;
                    end
                    if (cdb_valid && !ent_reg[i].r2 && ent_reg[i].q2 == cdb_tag) begin
                        ent_next[i].v2 = cdb_data;
                        ent_next[i].r2 = 1'b1;
                    end
                    if (ent_next[i].r1 && ent_next[i].r2)
                        ent_next[i].state = READY;
                end
                READY: begin
                    if (disp_fire && sel_index == IW'(i))
                        ent_next[i].state = EXEC;
                end
                EXEC: begin
                    if (ex_done && ex_done_index == IW'(i)) begin
                        ent_next[i].state = FREE;
                        ent_next[i].age   = 2'd0;
                    end
                end
                default: ;
            endcase
            if (iss_accept && alloc_idx == IW'(i))
                ent_next[i] = alloc_entry;
        end
    end

    // Selected entry contents for the dispatch registers.
    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (sel_index == IW'(i))
                sel_entry = ent_reg[i];
        end
    end

    // Free-slot availability after this edge, so iss_ready can be registered.
    always_comb begin
        iss_ready_next = 1'b0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (ent_next[i].state == FREE)
                iss_ready_next = 1'b1;
        end
    end

    // Occupancy straight from the entry registers.
    always_comb begin
        occ_count = 2'd0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (!free_vec[i])
                occ_count = occ_count + 2'd1;
        end
    end

    // State registers, dispatch registers and the sticky overflow flag.
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++)
                ent_reg[i] <= '0;
            iss_ready_reg  <= 1'b1;
            disp_valid_reg <= 1'b0;
            disp_func_reg  <= '0;
            disp_rs1_reg   <= '0;
            disp_rs2_reg   <= '0;
            disp_rob_reg   <= '0;
            disp_rd_reg    <= '0;
            disp_idx_reg   <= '0;
            err_ovf_reg    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENT; i++)
                ent_reg[i] <= ent_next[i];
            iss_ready_reg  <= iss_ready_next;
            disp_valid_reg <= disp_fire;
            if (disp_fire) begin
                disp_func_reg <= sel_entry.func;
                disp_rs1_reg  <= sel_entry.v1;
                disp_rs2_reg  <= sel_entry.v2;
                disp_rob_reg  <= sel_entry.rob;
                disp_rd_reg   <= sel_entry.rd;
                disp_idx_reg  <= sel_index;
            end
            if (iss_valid && !iss_ready_reg)
                err_ovf_reg <= 1'b1;
        end
    end

    assign iss_ready     = iss_ready_reg;
    assign disp_valid    = disp_valid_reg;
    assign disp_func     = disp_func_reg;
    assign disp_rs1_data = disp_rs1_reg;
    assign disp_rs2_data = disp_rs2_reg;
    assign disp_rob      = disp_rob_reg;
    assign disp_rd       = disp_rd_reg;
    assign disp_rs_index = disp_idx_reg;
    assign err_ovf       = err_ovf_reg;

endmodule
